// File: rtl/uart_boot_loader.sv
// UART boot loader: drives the UART register map as a bus initiator. It
// receives a framed program image, writes it into instruction memory,
// answers ACK/NAK, and releases the core from reset once a frame is accepted.
module uart_boot_loader #(
    parameter int unsigned CLOCK_FREQ     = 125_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter logic [31:0] UART_BASE      = 32'h8000_0000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd12_500_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_en_i,
    output logic [31:0] uart_addr_o,
    output logic        uart_write_o,
    output logic        uart_read_o,
    output logic [3:0]  uart_size_o,
    output logic [31:0] uart_dout_o,
    input  logic [31:0] uart_din_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        boot_done_o,
    output logic        core_rst_no
);

    localparam logic [31:0] ADDR_CTRL   = UART_BASE;
    localparam logic [31:0] ADDR_RECV   = UART_BASE + 32'h4;
    localparam logic [31:0] ADDR_TRANS  = UART_BASE + 32'h8;
    localparam logic [31:0] ADDR_EDGE   = UART_BASE + 32'hC;
    localparam logic [31:0] ADDR_SAMPLE = UART_BASE + 32'h10;
    localparam logic [31:0] EDGE_TIME   = 32'(CLOCK_FREQ / BAUD_RATE);
    localparam logic [31:0] SAMPLE_TIME = EDGE_TIME >> 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_EDGE, S_INIT_SAMPLE, S_POLL_REQ, S_POLL_CHK,
        S_RECV_REQ, S_RECV_CAP, S_GAP, S_MEM_WR, S_TX_POLL_REQ,
        S_TX_POLL_CHK, S_TX_WRITE, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_SYNC, PH_ADDR, PH_CNT, PH_DATA, PH_CSUM
    } phase_t;

    state_t      r_state, w_next;
    phase_t      r_phase;
    logic [1:0]  r_cnt;
    logic [31:0] r_base;
    logic [15:0] r_nwords;
    logic [15:0] r_k;
    logic [31:0] r_word;
    logic [7:0]  r_csum;
    logic        r_word_done;
    logic        r_csum_done;
    logic        r_ack;
    logic [31:0] r_timer;
    logic [31:0] r_addr_hold;
    logic [3:0]  r_size_hold;

    logic        w_rd, w_wr;
    logic [31:0] w_addr, w_dout;
    logic [3:0]  w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_cnt_new;
    logic        w_timeout;
    logic        w_unused_din;

    assign w_byte       = uart_din_i[7:0];
    assign w_unused_din = ^uart_din_i[31:8];
    assign w_cnt_new    = {w_byte, r_nwords[15:8]};
    assign w_timeout    = (TIMEOUT_CYCLES != 32'd0) && (r_phase != PH_SYNC) &&
                          (r_timer == TIMEOUT_CYCLES - 32'd1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and bus strobes; address/size hold their last value when idle
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = r_addr_hold;
        w_size = r_size_hold;
        w_dout = '0;
        case (r_state)
            S_IDLE:        w_next = boot_en_i ? S_INIT_EDGE : S_DONE;
            S_INIT_EDGE: begin
                w_wr = 1'b1; w_addr = ADDR_EDGE; w_size = 4'b1111; w_dout = EDGE_TIME;
                w_next = S_INIT_SAMPLE;
            end
            S_INIT_SAMPLE: begin
                w_wr = 1'b1; w_addr = ADDR_SAMPLE; w_size = 4'b1111; w_dout = SAMPLE_TIME;
                w_next = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                w_rd = 1'b1; w_addr = ADDR_CTRL; w_size = 4'b1111;
                w_next = S_POLL_CHK;
            end
            S_POLL_CHK:    w_next = uart_din_i[1] ? S_RECV_REQ : S_POLL_REQ;
            S_RECV_REQ: begin
                w_rd = 1'b1; w_addr = ADDR_RECV; w_size = 4'b1111;
                w_next = S_RECV_CAP;
            end
            S_RECV_CAP:    w_next = S_GAP;
            S_GAP: begin
                if (r_word_done)      w_next = S_MEM_WR;
                else if (r_csum_done) w_next = S_TX_POLL_REQ;
                else                  w_next = S_POLL_REQ;
            end
            S_MEM_WR:      w_next = S_POLL_REQ;
            S_TX_POLL_REQ: begin
                w_rd = 1'b1; w_addr = ADDR_CTRL; w_size = 4'b1111;
                w_next = S_TX_POLL_CHK;
            end
            S_TX_POLL_CHK: w_next = uart_din_i[0] ? S_TX_WRITE : S_TX_POLL_REQ;
            S_TX_WRITE: begin
                w_wr = 1'b1; w_addr = ADDR_TRANS; w_size = 4'b0001;
                w_dout = r_ack ? 32'h06 : 32'h15;
                w_next = r_ack ? S_DONE : S_POLL_REQ;
            end
            S_DONE:        w_next = S_DONE;
            default:       w_next = S_IDLE;
        endcase
    end

    // Frame parser, checksum, word assembly and inter-byte timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase     <= PH_SYNC;
            r_cnt       <= '0;
            r_base      <= '0;
            r_nwords    <= '0;
            r_k         <= '0;
            r_word      <= '0;
            r_csum      <= '0;
            r_word_done <= 1'b0;
            r_csum_done <= 1'b0;
            r_ack       <= 1'b0;
            r_timer     <= '0;
            r_addr_hold <= '0;
            r_size_hold <= '0;
        end else begin
            r_addr_hold <= w_addr;
            r_size_hold <= w_size;
            if (r_state == S_RECV_CAP) begin
                r_timer <= '0;
                case (r_phase)
                    PH_SYNC: begin
                        if (w_byte == 8'h55) begin
                            r_phase <= PH_ADDR;
                            r_cnt   <= '0;
                            r_csum  <= '0;
                            r_k     <= '0;
                        end
                    end
                    PH_ADDR: begin
                        r_base <= {w_byte, r_base[31:8]};
                        r_csum <= r_csum + w_byte;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) r_phase <= PH_CNT;
                    end
                    PH_CNT: begin
                        r_nwords <= w_cnt_new;
                        r_csum   <= r_csum + w_byte;
                        if (r_cnt == 2'd1) begin
                            r_cnt   <= '0;
                            r_k     <= '0;
                            r_phase <= (w_cnt_new == 16'd0) ? PH_CSUM : PH_DATA;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                    PH_DATA: begin
                        r_word <= {w_byte, r_word[31:8]};
                        r_csum <= r_csum + w_byte;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) r_word_done <= 1'b1;
                    end
                    PH_CSUM: begin
                        r_ack       <= (w_byte == r_csum);
                        r_csum_done <= 1'b1;
                    end
                    default: r_phase <= PH_SYNC;
                endcase
            end else begin
                if (r_state == S_GAP) begin
                    r_word_done <= 1'b0;
                    r_csum_done <= 1'b0;
                end
                if (r_phase == PH_SYNC || w_timeout) r_timer <= '0;
                else                                 r_timer <= r_timer + 32'd1;

                if (r_state == S_MEM_WR) begin
                    r_k <= r_k + 16'd1;
                    if (r_k == r_nwords - 16'd1) r_phase <= PH_CSUM;
                end else if (r_state == S_TX_WRITE && !r_ack) begin
                    r_phase <= PH_SYNC;
                    r_csum  <= '0;
                end else if (w_timeout) begin
                    r_phase <= PH_SYNC;
                    r_csum  <= '0;
                end
            end
        end
    end

    assign uart_addr_o  = w_addr;
    assign uart_write_o = w_wr;
    assign uart_read_o  = w_rd;
    assign uart_size_o  = w_size;
    assign uart_dout_o  = w_dout;
    assign mem_we_o     = (r_state == S_MEM_WR);
    assign mem_addr_o   = r_base + {14'b0, r_k, 2'b00};
    assign mem_wdata_o  = r_word;
    assign boot_done_o  = (r_state == S_DONE);
    assign core_rst_no  = boot_done_o;

endmodule
